uart_host_ctrl: RTL and testbench
=================================

Name: uart_host_ctrl

Overview:
- Register-mapped host-side controller for the existing uart core; it drives that core's start_tx/tx_done and rx_available/rx_clear handshakes from the other end.
- Sits between the CPU load/store bus and the uart core.
- Provides a small TX FIFO, a one-byte RX holding register with overrun detection, and a programmable baud divider register.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of 2, ≥2).
- BAUD_RESET, 12'd103, reset value of the baud divider register.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- addr  in  2  register select: 0=DATA, 1=STATUS, 2=BAUD, 3=CTRL.
- wr_en  in  1  write strobe, single cycle.
- rd_en  in  1  read strobe, single cycle.
- wdata  in  16  write data.
- rdata  out  16  read data, combinational from addr; 0 when rd_en=0.
- start_tx  out  1  to uart; held high until tx_done seen.
- tx_value  out  8  to uart; stable while start_tx high.
- tx_done  in  1  from uart.
- rx_available  in  1  from uart.
- rx_value  in  8  from uart; valid while rx_available high.
- rx_clear  out  1  to uart; acknowledges a received byte.
- uart_baud_counter  out  12  to uart; mirrors the BAUD register.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0 except uart_baud_counter=BAUD_RESET.
  - FIFO empty; rx_valid=0; sticky flags 0; tx_en=1; both FSMs IDLE.
- Registers:
  - DATA write: push wdata[7:0] into TX FIFO. If full, drop the byte and set sticky tx_ovf.
  - DATA read: rdata={8'd0,rx_hold}; on that edge clear rx_valid (pop).
  - STATUS read: [0]tx_full [1]tx_empty [2]tx_busy (TX FSM not IDLE) [3]rx_valid [4]rx_ovr [5]tx_ovf [8+:4]fifo count, 0..TX_DEPTH.
  - BAUD read/write: [11:0]; takes effect on the next cycle, including mid-frame.
  - CTRL read/write: [0]tx_en. Writing 1 to [1] clears rx_ovr; writing 1 to [2] clears tx_ovf; both read 0.
- TX FSM (IDLE, SEND, RELEASE):
  - IDLE: if tx_en and FIFO non-empty, load tx_value from head, assert start_tx next cycle, go to SEND.
  - SEND: hold start_tx and tx_value. On tx_done=1: deassert start_tx, pop FIFO head, go to RELEASE.
  - RELEASE: wait for tx_done=0, then go to IDLE. Minimum byte-to-byte gap is 3 clk.
  - Clearing tx_en mid-byte finishes the current byte; no new byte starts.
- Simultaneous push and pop: count unchanged, written byte retained. Push when full and pop in the same cycle: push accepted.
- RX FSM (IDLE, ACK):
  - IDLE, rx_available=1:
    - If rx_valid=0: capture rx_value into rx_hold and set rx_valid.
    - Else keep the old byte and set rx_ovr.
    - Assert rx_clear; go to ACK.
  - ACK: hold rx_clear until rx_available=0, then deassert and go to IDLE. rx_clear is high for ≥2 cycles.
- DATA read in the same cycle as a capture: the read returns the old byte; the new byte is stored, rx_valid stays 1, no overrun.
- Reset mid-frame: start_tx and rx_clear drop immediately; FIFO contents are lost.

Optional Feature:
- Macro UART_HOST_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, registered, reset 0).
  - CTRL[3]=rx_ie, CTRL[4]=tx_ie.
  - irq = (rx_valid & rx_ie) | (tx_empty & ~tx_busy & tx_ie) | rx_ovr.
- Undefined: no irq port; CTRL[4:3] read 0 and writes are ignored.

Test Plan:
- Reset → BAUD reads 103, STATUS reads 0x0002, start_tx=0, rx_clear=0, uart_baud_counter=103.
- Write DATA 0x41, 0x42; model tx_done 10 cycles after start_tx → tx_value 0x41 then 0x42, each start_tx held until tx_done, gap ≥3 cycles, STATUS tx_empty=1 at end.
- Write DATA 5 times with tx_en=0, TX_DEPTH=4 → count=4, tx_full=1, tx_ovf=1. Set tx_en=1 → exactly 4 bytes sent in order.
- Pulse rx_available with 0x5A, hold until rx_clear → rx_clear high ≥2 cycles, rx_valid=1. DATA read returns 0x005A and rx_valid goes to 0.
- Two RX bytes 0x11, 0x22 without a read → DATA returns 0x11, rx_ovr=1. CTRL write 0x0002 → rx_ovr=0.
- Assert rst during SEND → start_tx=0 in the same cycle, count=0, BAUD=103.

Source files
------------

// File: rtl/uart_host_ctrl.sv
// Host-side register front end for the uart core: TX FIFO, RX holding register, baud divider.
// Define UART_HOST_IRQ_EN to add the registered irq output and the CTRL interrupt-enable bits.
module uart_host_ctrl #(
    parameter int          TX_DEPTH   = 4,
    parameter logic [11:0] BAUD_RESET = 12'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        start_tx,
    output logic [7:0]  tx_value,
    input  logic        tx_done,
    input  logic        rx_available,
    input  logic [7:0]  rx_value,
    output logic        rx_clear,
`ifdef UART_HOST_IRQ_EN
    output logic        irq,
`endif
    output logic [11:0] uart_baud_counter
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_RELEASE} tx_state_e;
    typedef enum logic {RX_IDLE, RX_ACK} rx_state_e;

    tx_state_e      tx_state_q, tx_state_d;
    rx_state_e      rx_state_q, rx_state_d;
    logic           ack_min_q;
    logic [7:0]     tx_value_q, tx_value_d;
    logic [7:0]     fifo_q [TX_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     rx_hold_q;
    logic           rx_valid_q, rx_ovr_q, tx_ovf_q, tx_en_q;
    logic [11:0]    baud_q;
    logic [15:0]    ctrl_rd;
    logic           tx_full, tx_empty, tx_busy, tx_pop, push_ok;
    logic           wr_data, rd_data, wr_baud, wr_ctrl;
    logic           rx_capture, rx_free;
    logic           unused_wdata;

    assign wr_data    = wr_en && (addr == 2'd0);
    assign rd_data    = rd_en && (addr == 2'd0);
    assign wr_baud    = wr_en && (addr == 2'd2);
    assign wr_ctrl    = wr_en && (addr == 2'd3);
    assign tx_full    = (cnt_q == CW'(TX_DEPTH));
    assign tx_empty   = (cnt_q == '0);
    assign tx_pop     = (tx_state_q == TX_SEND) && tx_done;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok    = wr_data && (!tx_full || tx_pop);
    assign rx_capture = (rx_state_q == RX_IDLE) && rx_available;
    assign rx_free    = !rx_valid_q || rd_data;
    assign unused_wdata = ^wdata[15:12];

    assign tx_value          = tx_value_q;
    assign uart_baud_counter = baud_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TX_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= wdata[7:0];
                wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (tx_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !tx_pop)      cnt_q <= cnt_q + CW'(1);
            else if (!push_ok && tx_pop) cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_value_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_value_q <= tx_value_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_value_d = tx_value_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_en_q && !tx_empty) begin
                    tx_value_d = fifo_q[rd_ptr_q];
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND:    if (tx_done)  tx_state_d = TX_RELEASE;
            TX_RELEASE: if (!tx_done) tx_state_d = TX_IDLE;
            default:    tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        start_tx = (tx_state_q == TX_SEND);
        tx_busy  = (tx_state_q != TX_IDLE);
    end

    // ack_min_q keeps rx_clear up for a second cycle even if the core drops rx_available at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            ack_min_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            ack_min_q  <= (rx_state_q == RX_ACK);
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: if (rx_available)               rx_state_d = RX_ACK;
            RX_ACK:  if (ack_min_q && !rx_available) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_clear = (rx_state_q == RX_ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold_q  <= '0;
            rx_valid_q <= 1'b0;
        end else if (rx_capture && rx_free) begin
            rx_hold_q  <= rx_value;
            rx_valid_q <= 1'b1;
        end else if (rd_data) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Setting a sticky flag wins over a clear request on the same edge so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
        end else begin
            if (wr_data && tx_full && !tx_pop) tx_ovf_q <= 1'b1;
            else if (wr_ctrl && wdata[2])      tx_ovf_q <= 1'b0;
            if (rx_capture && !rx_free)        rx_ovr_q <= 1'b1;
            else if (wr_ctrl && wdata[1])      rx_ovr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q  <= BAUD_RESET;
            tx_en_q <= 1'b1;
        end else begin
            if (wr_baud) baud_q  <= wdata[11:0];
            if (wr_ctrl) tx_en_q <= wdata[0];
        end
    end

`ifdef UART_HOST_IRQ_EN
    logic rx_ie_q, tx_ie_q, irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ie_q <= 1'b0;
            tx_ie_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_ie_q <= wdata[3];
                tx_ie_q <= wdata[4];
            end
            irq_q <= (rx_valid_q & rx_ie_q) | (tx_empty & ~tx_busy & tx_ie_q) | rx_ovr_q;
        end
    end

    assign irq     = irq_q;
    assign ctrl_rd = {11'd0, tx_ie_q, rx_ie_q, 2'd0, tx_en_q};
`else
    assign ctrl_rd = {15'd0, tx_en_q};
`endif

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (addr)
                2'd0:    rdata = {8'd0, rx_hold_q};
                2'd1:    rdata = {4'd0, 4'(cnt_q), 2'd0, tx_ovf_q, rx_ovr_q,
                                  rx_valid_q, tx_busy, tx_empty, tx_full};
                2'd2:    rdata = {4'd0, baud_q};
                default: rdata = ctrl_rd;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_host_ctrl.sv
// Bench for uart_host_ctrl: queue-based reference model, emulated uart core, directed and random traffic.
module tb_uart_host_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 0, rst = 1;
    logic [1:0]  addr = 0;
    logic        wr_en = 0, rd_en = 0;
    logic [15:0] wdata = 0;
    logic [15:0] rdata;
    logic        start_tx;
    logic [7:0]  tx_value;
    logic        tx_done = 0;
    logic        rx_available = 0;
    logic [7:0]  rx_value = 0;
    logic        rx_clear;
    logic [11:0] uart_baud_counter;
`ifdef UART_HOST_IRQ_EN
    logic        irq;
`endif

    uart_host_ctrl #(.TX_DEPTH(DEPTH), .BAUD_RESET(12'd103)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wdata(wdata), .rdata(rdata), .start_tx(start_tx), .tx_value(tx_value),
        .tx_done(tx_done), .rx_available(rx_available), .rx_value(rx_value),
        .rx_clear(rx_clear),
`ifdef UART_HOST_IRQ_EN
        .irq(irq),
`endif
        .uart_baud_counter(uart_baud_counter)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_q[$];
    bit          m_inflight = 0, m_releasing = 0, m_tx_en = 1;
    bit          m_ovf = 0, m_ovr = 0, m_valid = 0, m_ack = 0;
    int          m_ack_age = 0;
    logic [7:0]  m_cur = 0, m_hold = 0;
    logic [11:0] m_baud = 12'd103;
    logic [7:0]  sent[$];
    int          since_done = 0;
    bit          prev_start = 0, had_done = 0;
    bit          wr_d, rd_d, wr_b, wr_c, popped, ovf_set, ovr_set, capture;
    int          pre;

    function automatic logic [15:0] model_rdata(logic [1:0] a);
        logic [15:0] s;
        s = 16'd0;
        case (a)
            2'd0: s = {8'd0, m_hold};
            2'd1: begin
                s[0]    = (m_q.size() == DEPTH);
                s[1]    = (m_q.size() == 0);
                s[2]    = m_inflight || m_releasing;
                s[3]    = m_valid;
                s[4]    = m_ovr;
                s[5]    = m_ovf;
                s[11:8] = 4'(m_q.size());
            end
            2'd2: s = {4'd0, m_baud};
            default: s = {15'd0, m_tx_en};
        endcase
        return s;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_start_tx", start_tx, 0);
            chk("rst_rx_clear", rx_clear, 0);
            chk("rst_tx_value", tx_value, 0);
            chk("rst_baud_out", uart_baud_counter, 103);
            m_q.delete();
            m_inflight = 0; m_releasing = 0; m_tx_en = 1;
            m_ovf = 0; m_ovr = 0; m_valid = 0; m_ack = 0; m_ack_age = 0;
            m_hold = 0; m_baud = 12'd103;
            prev_start = 0; had_done = 0; since_done = 0;
        end else begin
            chk("start_tx", start_tx, m_inflight);
            if (m_inflight) chk("tx_value", tx_value, m_cur);
            chk("rx_clear", rx_clear, m_ack);
            chk("baud_out", uart_baud_counter, m_baud);
            chk("rdata", rdata, rd_en ? model_rdata(addr) : 16'd0);

            since_done++;
            if (start_tx && !prev_start && had_done) begin
                checks++;
                if (since_done < 3) begin
                    failures++;
                    $display("FAIL tx_gap cycles=%0d required>=3 t=%0t", since_done, $time);
                end
            end
            if (start_tx && tx_done) begin
                sent.push_back(tx_value);
                since_done = 0;
                had_done = 1;
            end
            prev_start = start_tx;

            wr_d = wr_en && addr == 2'd0;
            rd_d = rd_en && addr == 2'd0;
            wr_b = wr_en && addr == 2'd2;
            wr_c = wr_en && addr == 2'd3;
            popped = 0; ovf_set = 0; ovr_set = 0;
            pre = m_q.size();
            if (m_inflight) begin
                if (tx_done) begin
                    void'(m_q.pop_front());
                    m_inflight = 0; m_releasing = 1; popped = 1;
                end
            end else if (m_releasing) begin
                if (!tx_done) m_releasing = 0;
            end else if (m_tx_en && pre > 0) begin
                m_inflight = 1;
                m_cur = m_q[0];
            end
            if (wr_d) begin
                if (pre < DEPTH || popped) m_q.push_back(wdata[7:0]);
                else ovf_set = 1;
            end

            capture = !m_ack && rx_available;
            if (capture) begin
                if (!m_valid || rd_d) begin m_hold = rx_value; m_valid = 1; end
                else ovr_set = 1;
            end else if (rd_d) m_valid = 0;
            if (capture) begin
                m_ack = 1; m_ack_age = 1;
            end else if (m_ack) begin
                if (m_ack_age >= 2 && !rx_available) m_ack = 0;
                else m_ack_age++;
            end

            if (wr_c) begin
                m_tx_en = wdata[0];
                if (wdata[1]) m_ovr = 0;
                if (wdata[2]) m_ovf = 0;
            end
            if (ovf_set) m_ovf = 1;
            if (ovr_set) m_ovr = 1;
            if (wr_b) m_baud = wdata[11:0];
        end
    end

    // ---------------- uart core emulation ----------------
    int         tx_lat_lo = 10, tx_lat_hi = 10, tx_hold_hi = 1;
    int         tx_cnt = 0, tx_lat = 0, tx_hold = 0;
    logic [7:0] rx_q[$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            tx_done = 0; tx_cnt = 0; tx_hold = 0;
            rx_available = 0;
            rx_q.delete();
        end else begin
            if (tx_hold > 0) begin
                tx_hold--;
                if (tx_hold == 0) tx_done = 0;
            end else if (start_tx) begin
                if (tx_cnt == 0) tx_lat = $urandom_range(tx_lat_hi, tx_lat_lo);
                tx_cnt++;
                if (tx_cnt >= tx_lat) begin
                    tx_done = 1;
                    tx_hold = $urandom_range(tx_hold_hi, 1);
                    tx_cnt = 0;
                end
            end
            if (rx_available) begin
                if (rx_clear) rx_available = 0;
            end else if (!rx_clear && rx_q.size() > 0) begin
                rx_value = rx_q.pop_front();
                rx_available = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] v);
        addr = a; wdata = v; wr_en = 1;
        cycle();
        wr_en = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        addr = a; rd_en = 1;
        @(negedge clk);
        d = rdata;
        cycle();
        rd_en = 0;
    endtask

    task automatic drain(string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 2000; k++) begin
            if (m_q.size() == 0 && !m_inflight && !m_releasing && !tx_done && !start_tx) begin
                ok = 1;
                break;
            end
            cycle();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s drain_timeout queued=%0d start_tx=%0d", name, m_q.size(), start_tx);
        end
    endtask

    task automatic rx_settle(string name);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (rx_q.size() == 0 && !rx_available && !rx_clear) begin
                ok = 1;
                break;
            end
            cycle();
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s rx_timeout rx_available=%0d rx_clear=%0d", name, rx_available, rx_clear);
        end
    endtask

    logic [15:0] d;
    int          hi;
    int          r;

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        rd(2'd1, d); chk("reset_status", d, 16'h0002);
        rd(2'd2, d); chk("reset_baud", d, 16'd103);
        rd(2'd3, d); chk("reset_ctrl", d, 16'h0001);

        sent.delete();
        wr(2'd0, 16'h0041);
        wr(2'd0, 16'h0042);
        drain("two_bytes");
        chk("two_bytes_count", sent.size(), 2);
        if (sent.size() == 2) begin
            chk("two_bytes_first", sent[0], 8'h41);
            chk("two_bytes_second", sent[1], 8'h42);
        end
        rd(2'd1, d); chk("two_bytes_status", d, 16'h0002);

        wr(2'd3, 16'h0000);
        for (int i = 0; i < 5; i++) wr(2'd0, 16'h0010 + 16'(i));
        rd(2'd1, d); chk("full_status", d, 16'h0421);
        sent.delete();
        wr(2'd3, 16'h0005);
        drain("full_drain");
        chk("full_sent_count", sent.size(), 4);
        for (int i = 0; i < 4 && i < sent.size(); i++) chk("full_sent_byte", sent[i], 8'h10 + 8'(i));

        rx_q.push_back(8'h5A);
        for (int k = 0; k < 20 && !rx_clear; k++) cycle();
        hi = 0;
        for (int k = 0; k < 20 && rx_clear; k++) begin hi++; cycle(); end
        checks++;
        if (hi < 2) begin
            failures++;
            $display("FAIL rx_clear_len cycles=%0d required>=2", hi);
        end
        rd(2'd1, d); chk("rx_status_valid", d, 16'h000A);
        rd(2'd0, d); chk("rx_data", d, 16'h005A);
        rd(2'd1, d); chk("rx_status_popped", d, 16'h0002);

        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        rx_settle("rx_overrun");
        rd(2'd0, d); chk("ovr_data", d, 16'h0011);
        rd(2'd1, d); chk("ovr_status", d, 16'h0012);
        wr(2'd3, 16'h0002);
        rd(2'd1, d); chk("ovr_cleared", d, 16'h0002);
        rd(2'd3, d); chk("ctrl_tx_en_off", d, 16'h0000);
        wr(2'd3, 16'h0001);

        wr(2'd2, 16'h0123);
        wr(2'd0, 16'h00A1);
        wr(2'd0, 16'h00A2);
        wr(2'd0, 16'h00A3);
        for (int k = 0; k < 50 && !start_tx; k++) cycle();
        chk("pre_reset_start_tx", start_tx, 1);
        rst = 1;
        #1;
        chk("async_rst_start_tx", start_tx, 0);
        chk("async_rst_rx_clear", rx_clear, 0);
        cycle(); cycle();
        rst = 0;
        rd(2'd1, d); chk("post_rst_status", d, 16'h0002);
        rd(2'd2, d); chk("post_rst_baud", d, 16'd103);

        tx_lat_lo = 1; tx_lat_hi = 6; tx_hold_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            wr_en = 0; rd_en = 0;
            r = $urandom_range(99, 0);
            if (r < 15) begin
                addr = 2'd0; wdata = 16'($urandom); wr_en = 1;
            end else if (r < 35) begin
                addr = 2'($urandom_range(3, 0)); rd_en = 1;
            end else if (r < 38) begin
                addr = 2'd2; wdata = 16'($urandom); wr_en = 1;
            end else if (r < 42) begin
                addr = 2'd3;
                wdata = {13'd0, 2'($urandom_range(3, 0)), 1'($urandom_range(7, 0) != 0)};
                wr_en = 1;
            end
            if ($urandom_range(19, 0) == 0) rx_q.push_back(8'($urandom));
            cycle();
        end
        wr_en = 0; rd_en = 0;
        wr(2'd3, 16'h0001);
        drain("random_drain");
        rx_settle("random_rx");
        rd(2'd1, d); chk("final_tx_empty", d[1], 1);
        chk("final_count", d[11:8], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
